// File: rtl/zero_shuffle_pipe_gen_pkg.sv
// Shared types and defaults for the parametrised zero-shuffle delay pipe.
package zs_pipe_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_APPLY = 2'd2
  } zs_state_t;

  localparam int unsigned DEF_CHECK_PARALLELISM = 85;
  localparam int unsigned DEF_QUAN_SIZE         = 4;
  localparam int unsigned DEF_MAX_DEPTH         = 4;
  localparam int unsigned DEF_DEPTH_W           = 3;
  localparam int unsigned DEF_RESET_DEPTH       = 2;

  // Plane-major packing: plane b, lane i lives at bit b*lanes+i.
  function automatic int unsigned plane_bit(input int unsigned plane,
                                            input int unsigned lane,
                                            input int unsigned lanes);
    return plane * lanes + lane;
  endfunction

endpackage

// File: rtl/zero_shuffle_pipe_gen_or_reduce.sv
// Per-lane OR across all bit-planes; flags lanes carrying a nonzero value.
module zs_lane_or_reduce
  import zs_pipe_pkg::*;
#(
  parameter int unsigned CHECK_PARALLELISM = DEF_CHECK_PARALLELISM,
  parameter int unsigned QUAN_SIZE         = DEF_QUAN_SIZE
) (
  input  logic [QUAN_SIZE*CHECK_PARALLELISM-1:0] planes,
  output logic [CHECK_PARALLELISM-1:0]           lane_nz
);

  always_comb begin
    lane_nz = '0;
    for (int unsigned i = 0; i < CHECK_PARALLELISM; i++) begin
      for (int unsigned b = 0; b < QUAN_SIZE; b++) begin
        lane_nz[i] = lane_nz[i] | planes[plane_bit(b, i, CHECK_PARALLELISM)];
      end
    end
  end

endmodule

// File: rtl/zero_shuffle_pipe_gen.sv
// Run-time selectable delay for QUAN_SIZE bit-planes with valid/ready, flush and
// drain-then-apply depth reconfiguration; depth 0 is a combinational bypass.
module zero_shuffle_pipe_gen
  import zs_pipe_pkg::*;
#(
  parameter int unsigned CHECK_PARALLELISM = DEF_CHECK_PARALLELISM,
  parameter int unsigned QUAN_SIZE         = DEF_QUAN_SIZE,
  parameter int unsigned MAX_DEPTH         = DEF_MAX_DEPTH,
  parameter int unsigned DEPTH_W           = DEF_DEPTH_W,
  parameter int unsigned RESET_DEPTH       = DEF_RESET_DEPTH
) (
  input  logic                                   sys_clk,
  input  logic                                   rstn,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  input  logic [QUAN_SIZE*CHECK_PARALLELISM-1:0] in_planes,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [QUAN_SIZE*CHECK_PARALLELISM-1:0] out_planes,
  output logic [CHECK_PARALLELISM-1:0]           out_lane_nz,
  input  logic                                   flush,
  input  logic [DEPTH_W-1:0]                     cfg_depth,
  input  logic                                   cfg_load,
  output logic                                   cfg_busy,
  output logic [DEPTH_W-1:0]                     cur_depth
);

  localparam int unsigned W  = QUAN_SIZE * CHECK_PARALLELISM;
  localparam int unsigned IW = $clog2(MAX_DEPTH + 1);

  zs_state_t state, state_nxt;

  logic [W-1:0]         stage_data [MAX_DEPTH];
  logic [MAX_DEPTH-1:0] stage_vld;
  logic [DEPTH_W-1:0]   pend_depth;
  logic [DEPTH_W-1:0]   cfg_sat;
  logic [IW-1:0]        inflight;

  logic [W-1:0] tap_data;
  logic         tap_valid;
  logic         bypass, run, adv, accept, retire;
  logic         apply_now, pend_load;

  assign cfg_sat = (cfg_depth > DEPTH_W'(MAX_DEPTH)) ? DEPTH_W'(MAX_DEPTH) : cfg_depth;

  always_comb begin
    tap_data  = '0;
    tap_valid = 1'b0;
    for (int unsigned i = 0; i < MAX_DEPTH; i++) begin
      if (cur_depth == DEPTH_W'(i + 1)) begin
        tap_data  = stage_data[i];
        tap_valid = stage_vld[i];
      end
    end
  end

  always_comb begin
    bypass     = (cur_depth == '0);
    run        = (state == ST_RUN);
    adv        = !tap_valid || out_ready;
    in_ready   = run && !flush && (bypass ? out_ready : adv);
    accept     = in_valid && in_ready;
    out_valid  = bypass ? (in_valid && run && !flush) : tap_valid;
    out_planes = bypass ? in_planes : tap_data;
    retire     = out_valid && out_ready;
  end

  zs_lane_or_reduce #(
    .CHECK_PARALLELISM (CHECK_PARALLELISM),
    .QUAN_SIZE         (QUAN_SIZE)
  ) u_or_reduce (
    .planes  (out_planes),
    .lane_nz (out_lane_nz)
  );

  always_ff @(posedge sys_clk) begin
    if (!rstn) state <= ST_RUN;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    apply_now = 1'b0;
    pend_load = 1'b0;
    cfg_busy  = (state != ST_RUN);
    unique case (state)
      ST_RUN: begin
        if (cfg_load) begin
          pend_load = 1'b1;
          // A beat entering the registers this very cycle must drain first.
          state_nxt = (inflight == '0 && !(accept && !bypass)) ? ST_APPLY : ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        pend_load = cfg_load;
        if (inflight == '0) state_nxt = ST_APPLY;
      end
      ST_APPLY: begin
        apply_now = 1'b1;
        state_nxt = ST_RUN;
      end
      default: state_nxt = ST_RUN;
    endcase
    if (flush) begin
      pend_load = 1'b0;
      apply_now = (state != ST_RUN);
      state_nxt = ST_RUN;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!rstn) begin
      cur_depth  <= DEPTH_W'(RESET_DEPTH);
      pend_depth <= DEPTH_W'(RESET_DEPTH);
      inflight   <= '0;
    end else begin
      if (pend_load) pend_depth <= cfg_sat;
      if (apply_now) cur_depth  <= pend_depth;
      if (flush)                  inflight <= '0;
      else if (accept && !retire) inflight <= inflight + IW'(1);
      else if (!accept && retire) inflight <= inflight - IW'(1);
    end
  end

  // Stall is global: with the tap blocked, every stage holds, bubbles included.
  always_ff @(posedge sys_clk) begin
    if (!rstn) begin
      stage_vld <= '0;
      for (int unsigned i = 0; i < MAX_DEPTH; i++) stage_data[i] <= '0;
    end else begin
      if (adv) begin
        stage_data[0] <= in_planes;
        stage_vld[0]  <= accept && !bypass;
        for (int unsigned i = 1; i < MAX_DEPTH; i++) begin
          stage_data[i] <= stage_data[i-1];
          stage_vld[i]  <= stage_vld[i-1];
        end
      end
      if (flush || apply_now) stage_vld <= '0;
    end
  end

endmodule

// File: tb/tb_zero_shuffle_pipe_gen.sv
// Scoreboard bench for zero_shuffle_pipe_gen: directed beats, stalls, reconfig, flush, reset.
module tb_zero_shuffle_pipe_gen;

  localparam int CP = 85;
  localparam int QS = 4;
  localparam int W  = CP * QS;

  logic          sys_clk = 1'b0;
  logic          rstn, in_valid, in_ready, out_valid, out_ready;
  logic          flush, cfg_load, cfg_busy;
  logic [W-1:0]  in_planes, out_planes;
  logic [CP-1:0] out_lane_nz;
  logic [2:0]    cfg_depth, cur_depth;

  zero_shuffle_pipe_gen #(
    .CHECK_PARALLELISM (85),
    .QUAN_SIZE         (4),
    .MAX_DEPTH         (4),
    .DEPTH_W           (3),
    .RESET_DEPTH       (2)
  ) dut (
    .sys_clk     (sys_clk),
    .rstn        (rstn),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_planes   (in_planes),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_planes  (out_planes),
    .out_lane_nz (out_lane_nz),
    .flush       (flush),
    .cfg_depth   (cfg_depth),
    .cfg_load    (cfg_load),
    .cfg_busy    (cfg_busy),
    .cur_depth   (cur_depth)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct { int k; int t; int lat; } exp_t;
  exp_t q[$];

  int vectors = 0;
  int errors  = 0;
  int cyc     = 0;
  int in_k    = 0;
  int lat_exp = 2;
  int inflight_lim = 0;

  always @(posedge sys_clk) cyc++;

  // Lane i of beat k carries value (3i+k) mod 11, so some lanes are zero.
  function automatic logic [W-1:0] pat(input int k);
    logic [W-1:0] p = '0;
    int v;
    for (int i = 0; i < CP; i++) begin
      v = (3 * i + k) % 11;
      for (int b = 0; b < QS; b++) p[b*CP+i] = v[b];
    end
    return p;
  endfunction

  function automatic logic [CP-1:0] nzexp(input int k);
    logic [CP-1:0] m = '0;
    for (int i = 0; i < CP; i++) m[i] = ((3 * i + k) % 11) != 0;
    return m;
  endfunction

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Scoreboard: record accepted beats, pop and compare on every retiring output.
  always @(negedge sys_clk) begin
    exp_t e;
    if (!rstn) q.delete();
    else begin
      if (in_valid && in_ready && !flush) q.push_back('{in_k, cyc, lat_exp});
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          vectors++; errors++;
          $display("FAIL spurious_out: got beat %h expected no output", out_planes);
        end else begin
          e = q.pop_front();
          chk($sformatf("planes_k%0d", e.k), out_planes, pat(e.k));
          chk($sformatf("lane_nz_k%0d", e.k), W'(out_lane_nz), W'(nzexp(e.k)));
          if (e.lat >= 0) chk($sformatf("latency_k%0d", e.k), W'(cyc - e.t), W'(e.lat));
        end
      end
      if (flush) q.delete();
      if (inflight_lim > 0) chk("inflight_bound", W'(q.size() <= inflight_lim), W'(1));
    end
  end

  task automatic send(input int k, input int lat);
    int n = 0;
    in_planes = pat(k); in_k = k; lat_exp = lat; in_valid = 1'b1;
    @(negedge sys_clk);
    while (!in_ready && n < 100) begin @(negedge sys_clk); n++; end
    if (n >= 100) begin
      vectors++; errors++;
      $display("FAIL send_timeout: beat %0d in_ready got 0 expected 1", k);
    end
    @(posedge sys_clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (q.size() != 0 && n < 100) begin @(negedge sys_clk); n++; end
    if (q.size() != 0) begin
      vectors++; errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", q.size());
    end
    @(posedge sys_clk); #1;
  endtask

  task automatic load_depth(input logic [2:0] d);
    int n = 0;
    cfg_depth = d; cfg_load = 1'b1;
    @(posedge sys_clk); #1;
    cfg_load = 1'b0;
    while (cfg_busy && n < 100) begin @(posedge sys_clk); #1; n++; end
    if (cfg_busy) begin
      vectors++; errors++;
      $display("FAIL cfg_timeout: cfg_busy got 1 expected 0");
    end
  endtask

  initial begin
    rstn = 1'b0; in_valid = 1'b0; out_ready = 1'b1; flush = 1'b0;
    cfg_load = 1'b0; cfg_depth = '0; in_planes = '0;
    repeat (3) @(posedge sys_clk);
    #1 rstn = 1'b1;
    @(negedge sys_clk);
    chk("rst_out_valid", W'(out_valid), W'(0));
    chk("rst_out_planes", out_planes, '0);
    chk("rst_lane_nz", W'(out_lane_nz), '0);
    chk("rst_cur_depth", W'(cur_depth), W'(2));
    chk("rst_cfg_busy", W'(cfg_busy), W'(0));
    chk("rst_in_ready", W'(in_ready), W'(1));
    @(posedge sys_clk); #1;

    // depth 2 streaming
    for (int k = 0; k < 10; k++) send(k, 2);
    wait_drain();

    // depth 3 with a 4-cycle downstream stall
    load_depth(3'd3);
    chk("cur_depth_3", W'(cur_depth), W'(3));
    inflight_lim = 3;
    fork
      begin
        for (int k = 20; k < 32; k++) send(k, -1);
      end
      begin
        repeat (6) @(posedge sys_clk);
        #1 out_ready = 1'b0;
        repeat (4) begin
          @(negedge sys_clk);
          chk("stall_in_ready", W'(in_ready), W'(0));
        end
        @(posedge sys_clk); #1 out_ready = 1'b1;
      end
    join
    wait_drain();
    inflight_lim = 0;

    // reconfigure to depth 4 with 3 beats in flight
    for (int k = 40; k < 43; k++) send(k, 3);
    cfg_depth = 3'd4; cfg_load = 1'b1;
    @(posedge sys_clk); #1 cfg_load = 1'b0;
    begin
      int n = 0;
      while (q.size() > 0 && n < 50) begin
        @(negedge sys_clk);
        chk("drain_cfg_busy", W'(cfg_busy), W'(1));
        chk("drain_in_ready", W'(in_ready), W'(0));
        n++;
      end
    end
    load_depth(3'd4);
    chk("cur_depth_4", W'(cur_depth), W'(4));
    send(45, 4); send(46, 4);
    wait_drain();

    // depth 0 bypass
    load_depth(3'd0);
    chk("cur_depth_0", W'(cur_depth), W'(0));
    in_planes = pat(50); in_k = 50; lat_exp = 0; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    chk("bypass_planes", out_planes, pat(50));
    chk("bypass_nz", W'(out_lane_nz), W'(nzexp(50)));
    chk("bypass_out_valid", W'(out_valid), W'(1));
    chk("bypass_ready_hi", W'(in_ready), W'(1));
    out_ready = 1'b0;
    #1 chk("bypass_ready_lo", W'(in_ready), W'(0));
    out_ready = 1'b1;
    @(posedge sys_clk); #1 in_valid = 1'b0;
    send(51, 0); send(52, 0);
    wait_drain();
    load_depth(3'd7);
    chk("cur_depth_sat", W'(cur_depth), W'(4));

    // flush while draining toward depth 3
    out_ready = 1'b0;
    send(60, -1); send(61, -1);
    cfg_depth = 3'd3; cfg_load = 1'b1;
    @(posedge sys_clk); #1 cfg_load = 1'b0;
    @(negedge sys_clk);
    chk("pre_flush_busy", W'(cfg_busy), W'(1));
    @(posedge sys_clk); #1;
    flush = 1'b1; in_valid = 1'b1; in_planes = pat(99); in_k = 99;
    @(negedge sys_clk);
    chk("flush_in_ready", W'(in_ready), W'(0));
    @(posedge sys_clk); #1;
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    @(negedge sys_clk);
    chk("post_flush_valid", W'(out_valid), W'(0));
    chk("post_flush_busy", W'(cfg_busy), W'(0));
    chk("post_flush_depth", W'(cur_depth), W'(3));
    @(posedge sys_clk); #1;
    send(62, 3);
    wait_drain();

    // reset with beats in flight at depth 3
    for (int k = 70; k < 73; k++) send(k, 3);
    rstn = 1'b0;
    @(posedge sys_clk); #1 rstn = 1'b1;
    @(negedge sys_clk);
    chk("mid_rst_valid", W'(out_valid), W'(0));
    chk("mid_rst_planes", out_planes, '0);
    chk("mid_rst_nz", W'(out_lane_nz), '0);
    chk("mid_rst_depth", W'(cur_depth), W'(2));
    chk("mid_rst_busy", W'(cfg_busy), W'(0));
    @(posedge sys_clk); #1;
    send(73, 2);
    wait_drain();
    repeat (4) @(posedge sys_clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
